// File: rtl/matrix_pkg.sv
// Shared constants and packing helpers for the 2x2 matrix blocks.
// Element order a11..a22 then b11..b22; a11 sits in the MSBs.
package matrix_pkg;

  localparam int ELEM_W_DEF = 2;
  localparam int MAT_ELEMS  = 4;
  localparam int PAIR_ELEMS = 8;
  localparam int IDX_W      = 3;

  localparam logic [IDX_W-1:0] IDX_A11 = 3'd0;
  localparam logic [IDX_W-1:0] IDX_A12 = 3'd1;
  localparam logic [IDX_W-1:0] IDX_A21 = 3'd2;
  localparam logic [IDX_W-1:0] IDX_A22 = 3'd3;
  localparam logic [IDX_W-1:0] IDX_B11 = 3'd4;
  localparam logic [IDX_W-1:0] IDX_B12 = 3'd5;
  localparam logic [IDX_W-1:0] IDX_B21 = 3'd6;
  localparam logic [IDX_W-1:0] IDX_B22 = 3'd7;

  // LSB of element k inside one packed 4-element matrix word.
  function automatic int elem_lsb(
    input int k,
    input int w
  );
    return (MAT_ELEMS - 1 - (k % MAT_ELEMS)) * w;
  endfunction

  // LSB of element k inside the packed {A,B} pair word.
  function automatic int pair_lsb(
    input int k,
    input int w
  );
    int base;
    base = (k < MAT_ELEMS) ? MAT_ELEMS * w : 0;
    return base + elem_lsb(k, w);
  endfunction

endpackage

// File: rtl/matrix_pair_slot.sv
// Registered holding register for one packed A/B pair plus a full flag.
// Ports: clk, rst, load/load_data, set_full, clr_full -> data, full.
module matrix_pair_slot
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [PAIR_ELEMS*ELEM_W-1:0] load_data,
  input  logic                         set_full,
  input  logic                         clr_full,
  output logic [PAIR_ELEMS*ELEM_W-1:0] data,
  output logic                         full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (load) begin
        data <= load_data;
      end
      // set wins so a refill in the draining cycle keeps the slot full
      if (set_full) begin
        full <= 1'b1;
      end else if (clr_full) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel loader: 8 elements in, one packed A/B pair out.
// Ports: in_* element stream, out_* pair stream, sync_err resync pulse.
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ELEM_W-1:0]     in_data,
  input  logic                  in_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*ELEM_W-1:0]   out_a,
  output logic [4*ELEM_W-1:0]   out_b,
  output logic                  sync_err
);

  localparam int PW = PAIR_ELEMS * ELEM_W;
  localparam int MW = MAT_ELEMS * ELEM_W;

  logic [IDX_W-1:0] idx_q;
  logic             sync_err_q;

  logic [PW-1:0]    asm_data;
  logic             asm_full;
  logic [PW-1:0]    out_data;
  logic             out_full;

  logic             accept;
  logic             drain;
  logic             resync;
  logic             last;
  logic             asm_done;
  logic             out_free;
  logic             xfer;
  logic [IDX_W-1:0] wr_idx;
  logic [PW-1:0]    asm_next;
  logic [PW-1:0]    xfer_data;
  logic             asm_set;

  assign in_ready = !asm_full;
  assign accept   = in_valid && in_ready;
  assign drain    = out_full && out_ready;

  // in_first mid-pair restarts assembly at a11
  assign resync = accept && in_first && (idx_q != IDX_A11);
  assign last   = accept && !resync && (idx_q == IDX_B22);
  assign wr_idx = resync ? IDX_A11 : idx_q;

  assign asm_done = last || asm_full;
  assign out_free = !out_full || drain;
  assign xfer     = asm_done && out_free;
  assign asm_set  = last && !out_free;

  always_comb begin
    asm_next = asm_data;
    asm_next[pair_lsb(int'(wr_idx), ELEM_W) +: ELEM_W] = in_data;
  end

  // a held pair is already complete; a finishing pair needs its 8th element
  assign xfer_data = asm_full ? asm_data : asm_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= IDX_A11;
    end else if (resync) begin
      idx_q <= IDX_A12;
    end else if (accept) begin
      if (idx_q == IDX_B22) begin
        idx_q <= IDX_A11;
      end else begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= resync;
    end
  end

  matrix_pair_slot #(
    .ELEM_W (ELEM_W)
  ) u_asm_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (asm_next),
    .set_full  (asm_set),
    .clr_full  (xfer),
    .data      (asm_data),
    .full      (asm_full)
  );

  matrix_pair_slot #(
    .ELEM_W (ELEM_W)
  ) u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .load_data (xfer_data),
    .set_full  (xfer),
    .clr_full  (drain),
    .data      (out_data),
    .full      (out_full)
  );

  assign out_valid = out_full;
  assign out_a     = out_data[PW-1:MW];
  assign out_b     = out_data[MW-1:0];
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader (ELEM_W=2).
// Directed scenarios plus a randomized scoreboard run.
module tb_matrix_operand_loader;

  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_data;
  logic          in_first;
  logic          out_valid;
  logic          out_ready;
  logic [4*EW-1:0] out_a;
  logic [4*EW-1:0] out_b;
  logic          sync_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matrix_operand_loader #(
    .ELEM_W (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .sync_err  (sync_err)
  );

  function automatic logic [4*EW-1:0] pk(
    input logic [EW-1:0] e0,
    input logic [EW-1:0] e1,
    input logic [EW-1:0] e2,
    input logic [EW-1:0] e3
  );
    return {e0, e1, e2, e3};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [EW-1:0] d, input logic f);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    while (!in_ready && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL push_timeout in_ready=%0b want=1", in_ready);
    end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    checks += 5;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%0b want=0", out_valid);
    end
    if (out_a !== 8'h00) begin
      failures++;
      $display("FAIL reset_out_a got=%h want=00", out_a);
    end
    if (out_b !== 8'h00) begin
      failures++;
      $display("FAIL reset_out_b got=%h want=00", out_b);
    end
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_sync_err got=%0b want=0", sync_err);
    end
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%0b want=1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [EW-1:0] e [8];
    e = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(e[i], i == 0);
      if (i == 6) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL basic_early_valid got=%0b want=0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_valid got=%0b want=1", out_valid);
    end
    if (out_a !== 8'h6C) begin
      failures++;
      $display("FAIL basic_out_a got=%h want=6c", out_a);
    end
    if (out_b !== 8'h93) begin
      failures++;
      $display("FAIL basic_out_b got=%h want=93", out_b);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle got=%0b want=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e [16];
    logic [4*EW-1:0] ea1, eb1, ea2, eb2;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e[i] = EW'($urandom_range(0, 3));
    end
    ea1 = pk(e[0], e[1], e[2], e[3]);
    eb1 = pk(e[4], e[5], e[6], e[7]);
    ea2 = pk(e[8], e[9], e[10], e[11]);
    eb2 = pk(e[12], e[13], e[14], e[15]);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_in_ready_%0d got=%0b want=1", i, in_ready);
      end
      push(e[i], i % 8 == 0);
    end
    in_valid = 1'b0;
    checks += 4;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_held got=%0b want=0", in_ready);
    end
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_valid got=%0b want=1", out_valid);
    end
    if (out_a !== ea1 || out_b !== eb1) begin
      failures++;
      $display("FAIL bp_pair1 got=%h_%h want=%h_%h",
               out_a, out_b, ea1, eb1);
    end
    cyc();
    cyc();
    if (out_valid !== 1'b1 || out_a !== ea1 || out_b !== eb1) begin
      failures++;
      $display("FAIL bp_stable got=%0b_%h_%h want=1_%h_%h",
               out_valid, out_a, out_b, ea1, eb1);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks += 3;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_valid got=%0b want=1", out_valid);
    end
    if (out_a !== ea2 || out_b !== eb2) begin
      failures++;
      $display("FAIL bp_pair2 got=%h_%h want=%h_%h",
               out_a, out_b, ea2, eb2);
    end
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got=%0b want=1", in_ready);
    end
    out_ready = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained got=%0b want=0", out_valid);
    end
  endtask

  task automatic test_throughput();
    logic [EW-1:0] b [8];
    logic [EW-1:0] d;
    logic exp_v;
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      d = EW'($urandom_range(0, 3));
      b[k % 8] = d;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL tp_in_ready_%0d got=%0b want=1", k, in_ready);
      end
      push(d, k % 8 == 0);
      exp_v = (k % 8 == 7);
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL tp_valid_%0d got=%0b want=%0b", k, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (out_a !== pk(b[0], b[1], b[2], b[3]) ||
            out_b !== pk(b[4], b[5], b[6], b[7])) begin
          failures++;
          $display("FAIL tp_pair_%0d got=%h_%h want=%h_%h", k, out_a, out_b,
                   pk(b[0], b[1], b[2], b[3]), pk(b[4], b[5], b[6], b[7]));
        end
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_resync();
    logic [EW-1:0] r [7];
    logic [EW-1:0] three;
    logic [4*EW-1:0] ea, eb;
    three = 2'b11;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(EW'($urandom_range(0, 3)), i == 0);
    end
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL rs_pre got=%0b want=0", sync_err);
    end
    push(three, 1'b1);
    checks++;
    if (sync_err !== 1'b1) begin
      failures++;
      $display("FAIL rs_pulse got=%0b want=1", sync_err);
    end
    for (int i = 0; i < 7; i++) begin
      r[i] = EW'($urandom_range(0, 3));
      push(r[i], 1'b0);
      if (i == 0) begin
        checks++;
        if (sync_err !== 1'b0) begin
          failures++;
          $display("FAIL rs_pulse_len got=%0b want=0", sync_err);
        end
      end
    end
    in_valid = 1'b0;
    ea = pk(three, r[0], r[1], r[2]);
    eb = pk(r[3], r[4], r[5], r[6]);
    checks += 3;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rs_valid got=%0b want=1", out_valid);
    end
    if (out_a[7:6] !== 2'b11) begin
      failures++;
      $display("FAIL rs_a11 got=%b want=11", out_a[7:6]);
    end
    if (out_a !== ea || out_b !== eb) begin
      failures++;
      $display("FAIL rs_pair got=%h_%h want=%h_%h", out_a, out_b, ea, eb);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] e [8];
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(EW'($urandom_range(1, 3)), i == 0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL rm_flags got=%0b%0b want=00", out_valid, sync_err);
    end
    if (out_a !== 8'h00 || out_b !== 8'h00) begin
      failures++;
      $display("FAIL rm_zero got=%h_%h want=00_00", out_a, out_b);
    end
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rm_ready got=%0b want=1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      e[i] = EW'($urandom_range(0, 3));
      push(e[i], 1'b0);
      if (i == 6) begin
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL rm_phantom got=%0b want=0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rm_valid got=%0b want=1", out_valid);
    end
    if (out_a !== pk(e[0], e[1], e[2], e[3]) ||
        out_b !== pk(e[4], e[5], e[6], e[7])) begin
      failures++;
      $display("FAIL rm_pair got=%h_%h want=%h_%h", out_a, out_b,
               pk(e[0], e[1], e[2], e[3]), pk(e[4], e[5], e[6], e[7]));
    end
    cyc();
  endtask

  task automatic test_random();
    logic [EW-1:0] buf8 [8];
    logic [8*EW-1:0] q [$];
    logic [8*EW-1:0] exp;
    logic [4*EW-1:0] pa, pb;
    logic acc, drn, stall, exp_err;
    int cnt, pairs, cycles, n;
    cnt = 0;
    pairs = 0;
    cycles = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cyc();
    while (pairs < 1000 && cycles < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = EW'($urandom_range(0, 3));
      in_first  = (cnt == 0) ? 1'($urandom_range(0, 1))
                             : ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra got=%h_%h want=none", out_a, out_b);
        end else begin
          exp = q.pop_front();
          if ({out_a, out_b} !== exp) begin
            failures++;
            $display("FAIL rnd_pair got=%h_%h want=%h",
                     out_a, out_b, exp);
          end
        end
      end
      exp_err = 1'b0;
      if (acc) begin
        if (in_first && cnt > 0) begin
          cnt = 0;
          exp_err = 1'b1;
        end
        buf8[cnt] = in_data;
        cnt++;
        if (cnt == 8) begin
          q.push_back({pk(buf8[0], buf8[1], buf8[2], buf8[3]),
                       pk(buf8[4], buf8[5], buf8[6], buf8[7])});
          cnt = 0;
          pairs++;
        end
      end
      stall = out_valid && !out_ready;
      pa = out_a;
      pb = out_b;
      cyc();
      cycles++;
      checks += 3;
      if (sync_err !== exp_err) begin
        failures++;
        $display("FAIL rnd_sync_err got=%0b want=%0b", sync_err, exp_err);
      end
      if (out_valid !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rnd_valid got=%0b want=%0b",
                 out_valid, q.size() > 0);
      end
      if (in_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rnd_in_ready got=%0b want=%0b",
                 in_ready, q.size() < 2);
      end
      if (stall) begin
        checks++;
        if (out_a !== pa || out_b !== pb) begin
          failures++;
          $display("FAIL rnd_stable got=%h_%h want=%h_%h",
                   out_a, out_b, pa, pb);
        end
      end
    end
    checks++;
    if (pairs < 1000) begin
      failures++;
      $display("FAIL rnd_budget got=%0d want=1000", pairs);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      if (out_valid) begin
        exp = q.pop_front();
        checks++;
        if ({out_a, out_b} !== exp) begin
          failures++;
          $display("FAIL rnd_drain got=%h_%h want=%h", out_a, out_b, exp);
        end
      end
      cyc();
      n++;
    end
    checks += 2;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rnd_lost got=%0d want=0", q.size());
    end
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rnd_final_valid got=%0b want=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_throughput();
    test_resync();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
